// File: rtl/instr_fetch_decoder.sv
// -----------------------------------------------------------------------------
// instr_fetch_decoder
//   Front-end fetch/decode stage. Walks byte-wide program memory from
//   START_ADDR, parses variable-length instruction records and presents each
//   decoded instruction to the execute stage over a valid/ready handshake.
//
//   Record formats:
//     0x02, opcode, A, B  -> two-operand
//     0x01, opcode, A     -> single-operand
//     0xFF                -> terminate
//
// Ports
//   clk          in   1   system clock, rising edge
//   rst_n        in   1   asynchronous active-low reset
//   enable       in   1   start/continue request
//   mem_rd       out  1   read strobe to program memory
//   mem_addr     out  AW  read address, valid while mem_rd=1
//   mem_rdata    in   8   read data, valid one cycle after mem_rd
//   ins_valid    out  1   decoded instruction available
//   ins_ready    in   1   execute stage accepts the instruction
//   ins_nops     out  2   operand count (1 or 2)
//   ins_opcode   out  6   ALU opcode
//   ins_op_a     out  8   operand A
//   ins_op_b     out  8   operand B (0 for single-operand records)
//   running      out  1   fetch/decode active
//   halted       out  1   terminate record reached (sticky until next start)
//   err_illegal  out  1   bad header/opcode byte (sticky until next start)
// -----------------------------------------------------------------------------
module instr_fetch_decoder #(
   parameter int unsigned   AW         = 10,
   parameter logic [AW-1:0] START_ADDR = {AW{1'b0}}
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          enable,
   output logic          mem_rd,
   output logic [AW-1:0] mem_addr,
   input  logic [7:0]    mem_rdata,
   output logic          ins_valid,
   input  logic          ins_ready,
   output logic [1:0]    ins_nops,
   output logic [5:0]    ins_opcode,
   output logic [7:0]    ins_op_a,
   output logic [7:0]    ins_op_b,
   output logic          running,
   output logic          halted,
   output logic          err_illegal
);

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_HDR   = 3'd1,
      ST_OPC   = 3'd2,
      ST_OPA   = 3'd3,
      ST_OPB   = 3'd4,
      ST_ISSUE = 3'd5,
      ST_HALT  = 3'd6,
      ST_ERR   = 3'd7
   } state_t;

   localparam logic [AW-1:0] PC_INC  = {{(AW-1){1'b0}}, 1'b1};
   localparam logic [7:0]    HDR_ONE = 8'h01;
   localparam logic [7:0]    HDR_TWO = 8'h02;
   localparam logic [7:0]    HDR_END = 8'hFF;

   state_t        state_r,     state_s;
   logic [AW-1:0] pc_r,        pc_s;
   logic [AW-1:0] mem_addr_r,  mem_addr_s;
   logic          mem_rd_r,    mem_rd_s;
   logic          ins_valid_r, ins_valid_s;
   logic [1:0]    nops_r,      nops_s;
   logic [5:0]    opcode_r,    opcode_s;
   logic [7:0]    op_a_r,      op_a_s;
   logic [7:0]    op_b_r,      op_b_s;
   logic          running_r,   running_s;
   logic          halted_r,    halted_s;
   logic          err_r,       err_s;

   // Next-state and next-output logic.
   // Every fetch state spends two cycles per byte: while mem_rd_r is high we
   // are in the request cycle (pc advances), otherwise in the capture cycle
   // where mem_rdata is consumed and the next request is launched.
   always_comb begin
      state_s     = state_r;
      pc_s        = pc_r;
      mem_addr_s  = mem_addr_r;
      mem_rd_s    = 1'b0;
      ins_valid_s = ins_valid_r;
      nops_s      = nops_r;
      opcode_s    = opcode_r;
      op_a_s      = op_a_r;
      op_b_s      = op_b_r;
      running_s   = running_r;
      halted_s    = halted_r;
      err_s       = err_r;

      case (state_r)
         ST_IDLE: begin
            if (enable) begin
               state_s    = ST_HDR;
               running_s  = 1'b1;
               halted_s   = 1'b0;
               err_s      = 1'b0;
               pc_s       = START_ADDR;
               mem_rd_s   = 1'b1;
               mem_addr_s = START_ADDR;
            end else begin
               state_s = ST_IDLE;
            end
         end

         ST_HDR: begin
            if (mem_rd_r) begin
               pc_s = pc_r + PC_INC;
            end else begin
               case (mem_rdata)
                  HDR_TWO: begin
                     nops_s     = 2'd2;
                     state_s    = ST_OPC;
                     mem_rd_s   = 1'b1;
                     mem_addr_s = pc_r;
                  end
                  HDR_ONE: begin
                     nops_s     = 2'd1;
                     state_s    = ST_OPC;
                     mem_rd_s   = 1'b1;
                     mem_addr_s = pc_r;
                  end
                  HDR_END: begin
                     state_s   = ST_HALT;
                     running_s = 1'b0;
                     halted_s  = 1'b1;
                  end
                  default: begin
                     state_s   = ST_ERR;
                     running_s = 1'b0;
                     err_s     = 1'b1;
                  end
               endcase
            end
         end

         ST_OPC: begin
            if (mem_rd_r) begin
               pc_s = pc_r + PC_INC;
            end else if (mem_rdata[7:6] != 2'b00) begin
               state_s   = ST_ERR;
               running_s = 1'b0;
               err_s     = 1'b1;
            end else begin
               opcode_s   = mem_rdata[5:0];
               state_s    = ST_OPA;
               mem_rd_s   = 1'b1;
               mem_addr_s = pc_r;
            end
         end

         ST_OPA: begin
            if (mem_rd_r) begin
               pc_s = pc_r + PC_INC;
            end else begin
               op_a_s = mem_rdata;
               if (nops_r == 2'd2) begin
                  state_s    = ST_OPB;
                  mem_rd_s   = 1'b1;
                  mem_addr_s = pc_r;
               end else begin
                  op_b_s      = 8'h00;
                  ins_valid_s = 1'b1;
                  state_s     = ST_ISSUE;
               end
            end
         end

         ST_OPB: begin
            if (mem_rd_r) begin
               pc_s = pc_r + PC_INC;
            end else begin
               op_b_s      = mem_rdata;
               ins_valid_s = 1'b1;
               state_s     = ST_ISSUE;
            end
         end

         // The enable check for the next header is taken on the handshake
         // edge, so the header read is only launched when still enabled.
         ST_ISSUE: begin
            if (ins_ready) begin
               ins_valid_s = 1'b0;
               if (enable) begin
                  state_s    = ST_HDR;
                  mem_rd_s   = 1'b1;
                  mem_addr_s = pc_r;
               end else begin
                  state_s   = ST_IDLE;
                  running_s = 1'b0;
               end
            end else begin
               ins_valid_s = 1'b1;
            end
         end

         // Parking in IDLE once enable is low gives the low-then-high restart
         // rule; the sticky flags survive until IDLE starts a new run.
         ST_HALT, ST_ERR: begin
            if (!enable) begin
               state_s = ST_IDLE;
            end else begin
               state_s = state_r;
            end
         end

         default: begin
            state_s     = ST_IDLE;
            running_s   = 1'b0;
            ins_valid_s = 1'b0;
         end
      endcase
   end

   // State and output registers; all outputs come straight from here
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r     <= ST_IDLE;
         pc_r        <= START_ADDR;
         mem_addr_r  <= {AW{1'b0}};
         mem_rd_r    <= 1'b0;
         ins_valid_r <= 1'b0;
         nops_r      <= 2'd0;
         opcode_r    <= 6'd0;
         op_a_r      <= 8'h00;
         op_b_r      <= 8'h00;
         running_r   <= 1'b0;
         halted_r    <= 1'b0;
         err_r       <= 1'b0;
      end else begin
         state_r     <= state_s;
         pc_r        <= pc_s;
         mem_addr_r  <= mem_addr_s;
         mem_rd_r    <= mem_rd_s;
         ins_valid_r <= ins_valid_s;
         nops_r      <= nops_s;
         opcode_r    <= opcode_s;
         op_a_r      <= op_a_s;
         op_b_r      <= op_b_s;
         running_r   <= running_s;
         halted_r    <= halted_s;
         err_r       <= err_s;
      end
   end

   assign mem_rd      = mem_rd_r;
   assign mem_addr    = mem_addr_r;
   assign ins_valid   = ins_valid_r;
   assign ins_nops    = nops_r;
   assign ins_opcode  = opcode_r;
   assign ins_op_a    = op_a_r;
   assign ins_op_b    = op_b_r;
   assign running     = running_r;
   assign halted      = halted_r;
   assign err_illegal = err_r;

endmodule

// File: tb/tb_instr_fetch_decoder.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch_decoder
//   Scoreboard bench for instr_fetch_decoder. A reference model walks the
//   program memory byte by byte and queues the expected instructions; monitor
//   processes pop and compare on each handshake and check fetch-address order,
//   read spacing and holding of the instruction while stalled.
// -----------------------------------------------------------------------------
module tb_instr_fetch_decoder;
   localparam int AW    = 10;
   localparam int MEMSZ = 1024;

   logic          clk;
   logic          rst_n, enable, ins_ready;
   logic          mem_rd;
   logic [AW-1:0] mem_addr;
   logic [7:0]    mem_rdata;
   logic          ins_valid;
   logic [1:0]    ins_nops;
   logic [5:0]    ins_opcode;
   logic [7:0]    ins_op_a, ins_op_b;
   logic          running, halted, err_illegal;

   logic          w_enable, w_ins_ready;
   logic          w_mem_rd;
   logic [AW-1:0] w_mem_addr;
   logic [7:0]    w_mem_rdata;
   logic          w_ins_valid;
   logic [1:0]    w_ins_nops;
   logic [5:0]    w_ins_opcode;
   logic [7:0]    w_ins_op_a, w_ins_op_b;
   logic          w_running, w_halted, w_err_illegal;

   logic [7:0]  mem  [MEMSZ];
   logic [7:0]  wmem [MEMSZ];
   logic [23:0] exp_q[$];
   logic [23:0] wexp_q[$];

   int vectors      = 0;
   int miscompares  = 0;
   int cyc          = 0;
   int rd_cnt       = 0;
   int wrd_cnt      = 0;
   int first_rd_cyc = -1;
   int first_vld_cyc = -1;
   int rmode        = 0;

   instr_fetch_decoder #(.AW(AW), .START_ADDR(10'h000)) u_dut (
      .clk(clk), .rst_n(rst_n), .enable(enable),
      .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
      .ins_valid(ins_valid), .ins_ready(ins_ready), .ins_nops(ins_nops),
      .ins_opcode(ins_opcode), .ins_op_a(ins_op_a), .ins_op_b(ins_op_b),
      .running(running), .halted(halted), .err_illegal(err_illegal)
   );

   instr_fetch_decoder #(.AW(AW), .START_ADDR(10'h3FE)) u_wrap (
      .clk(clk), .rst_n(rst_n), .enable(w_enable),
      .mem_rd(w_mem_rd), .mem_addr(w_mem_addr), .mem_rdata(w_mem_rdata),
      .ins_valid(w_ins_valid), .ins_ready(w_ins_ready), .ins_nops(w_ins_nops),
      .ins_opcode(w_ins_opcode), .ins_op_a(w_ins_op_a), .ins_op_b(w_ins_op_b),
      .running(w_running), .halted(w_halted), .err_illegal(w_err_illegal)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // Program memories: data valid the cycle after the read strobe
   always @(posedge clk) begin
      if (mem_rd) mem_rdata <= mem[mem_addr];
      if (w_mem_rd) w_mem_rdata <= wmem[w_mem_addr];
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [7:0] rdm(input bit use_w, input int p);
      return use_w ? wmem[p % MEMSZ] : mem[p % MEMSZ];
   endfunction

   // Reference model: walk records from start, queue expected instructions.
   // outcome: 0 = stopped after max_ins instructions, 1 = terminate, 2 = illegal
   task automatic model_run(input bit use_w, input int start, input int max_ins,
                            output int nbytes, output int outcome);
      int p, cnt;
      bit done;
      logic [7:0] h, op, a, b;
      p = start; cnt = 0; nbytes = 0; outcome = 0; done = 1'b0;
      while (!done) begin
         if (cnt >= max_ins || nbytes > 2048) begin
            done = 1'b1;
         end else begin
            h = rdm(use_w, p); p++; nbytes++;
            if (h == 8'hFF) begin
               outcome = 1; done = 1'b1;
            end else if (h != 8'h01 && h != 8'h02) begin
               outcome = 2; done = 1'b1;
            end else begin
               op = rdm(use_w, p); p++; nbytes++;
               if (op > 8'd63) begin
                  outcome = 2; done = 1'b1;
               end else begin
                  a = rdm(use_w, p); p++; nbytes++;
                  b = 8'h00;
                  if (h == 8'h02) begin
                     b = rdm(use_w, p); p++; nbytes++;
                  end
                  if (use_w) wexp_q.push_back({h[1:0], op[5:0], a, b});
                  else       exp_q.push_back({h[1:0], op[5:0], a, b});
                  cnt++;
               end
            end
         end
      end
   endtask

   // ins_ready driver: 0 = always ready, 1 = random, 2 = 5-cycle stall per instruction
   initial begin
      int stall;
      stall = 0;
      ins_ready = 1'b1;
      w_ins_ready = 1'b1;
      forever begin
         @(posedge clk); #1;
         if (ins_valid) begin
            case (rmode)
               0: ins_ready = 1'b1;
               1: ins_ready = 1'($urandom_range(0, 1));
               2: begin
                  if (stall < 5) begin ins_ready = 1'b0; stall++; end
                  else ins_ready = 1'b1;
               end
               default: ins_ready = 1'b1;
            endcase
         end else begin
            stall = 0;
            ins_ready = (rmode == 0);
         end
      end
   end

   // Monitor for the main instance
   initial begin
      bit prev_rd, hold;
      logic [23:0] snap, cur, e;
      prev_rd = 1'b0; hold = 1'b0; snap = 24'h0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            prev_rd = 1'b0; hold = 1'b0;
         end else begin
            cur = {ins_nops, ins_opcode, ins_op_a, ins_op_b};
            if (mem_rd) begin
               chk("rd_gap", 32'(prev_rd), 32'h0);
               chk("rd_during_issue", 32'(ins_valid), 32'h0);
               chk("rd_addr", 32'(mem_addr), 32'(rd_cnt % MEMSZ));
               if (first_rd_cyc < 0) first_rd_cyc = cyc;
               rd_cnt++;
            end
            if (ins_valid) begin
               if (first_vld_cyc < 0) first_vld_cyc = cyc;
               if (hold) chk("ins_hold", 32'(cur), 32'(snap));
               if (ins_ready) begin
                  if (exp_q.size() == 0) begin
                     chk("extra_ins", 32'(ins_valid), 32'h0);
                  end else begin
                     e = exp_q.pop_front();
                     chk("ins", 32'(cur), 32'(e));
                  end
                  hold = 1'b0;
               end else begin
                  hold = 1'b1; snap = cur;
               end
            end else begin
               if (hold) chk("valid_drop", 32'(ins_valid), 32'h1);
               hold = 1'b0;
            end
            prev_rd = mem_rd;
         end
      end
   end

   // Monitor for the wrap-around instance (START_ADDR = 0x3FE)
   initial begin
      logic [23:0] e;
      forever begin
         @(negedge clk);
         if (rst_n) begin
            if (w_mem_rd) begin
               chk("w_rd_addr", 32'(w_mem_addr), 32'((1022 + wrd_cnt) % MEMSZ));
               wrd_cnt++;
            end
            if (w_ins_valid && w_ins_ready) begin
               if (wexp_q.size() == 0) begin
                  chk("w_extra_ins", 32'(w_ins_valid), 32'h0);
               end else begin
                  e = wexp_q.pop_front();
                  chk("w_ins", 32'({w_ins_nops, w_ins_opcode, w_ins_op_a, w_ins_op_b}), 32'(e));
               end
            end
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // One run from START_ADDR; drop_at > 0 releases enable after that many cycles
   task automatic do_run(input int drop_at, input bit chk_lat);
      int nb, oc, c0, k;
      bit done;
      model_run(1'b0, 0, (drop_at > 0) ? 1 : 100000, nb, oc);
      rd_cnt = 0; first_rd_cyc = -1; first_vld_cyc = -1;
      enable = 1'b1; c0 = cyc; k = 0; done = 1'b0;
      while (!done && k < 20000) begin
         @(posedge clk); #1;
         k++;
         if (k == drop_at) enable = 1'b0;
         if (!running) done = 1'b1;
      end
      chk("run_timeout", 32'(done), 32'h1);
      enable = 1'b0;
      tick(3);
      chk("queue_empty", 32'(exp_q.size()), 32'h0);
      exp_q.delete();
      chk("rd_count", 32'(rd_cnt), 32'(nb));
      chk("halted", 32'(halted), 32'(oc == 1));
      chk("err_illegal", 32'(err_illegal), 32'(oc == 2));
      chk("running_end", 32'(running), 32'h0);
      if (chk_lat) begin
         chk("lat_first_rd", 32'(first_rd_cyc), 32'(c0 + 1));
         chk("lat_hdr_to_valid", 32'(first_vld_cyc - first_rd_cyc), 32'd8);
      end
   endtask

   task automatic load_t1();
      logic [7:0] prog [8];
      prog = '{8'h02, 8'h00, 8'h0F, 8'h0A, 8'h01, 8'h07, 8'hF0, 8'hFF};
      for (int i = 0; i < MEMSZ; i++) mem[i] = 8'h00;
      for (int i = 0; i < 8; i++) mem[i] = prog[i];
   endtask

   initial begin
      int nb, oc, k, saved, p, n;
      logic [7:0] h;
      rst_n = 1'b0; enable = 1'b0; w_enable = 1'b0;
      for (int i = 0; i < MEMSZ; i++) begin mem[i] = 8'h00; wmem[i] = 8'h00; end
      tick(3);
      chk("rst_ctl", 32'({mem_rd, mem_addr, ins_valid, ins_nops, running, halted, err_illegal}), 32'h0);
      chk("rst_ins", 32'({ins_opcode, ins_op_a, ins_op_b}), 32'h0);
      rst_n = 1'b1;
      tick(2);

      // 1: basic program, always ready, with latency checks
      load_t1(); rmode = 0;
      do_run(-1, 1'b1);
      chk("t1_rd_pulses", 32'(rd_cnt), 32'd8);

      // 2: same program, 5-cycle stall on each instruction
      tick(1); rmode = 2;
      do_run(-1, 1'b1);
      rmode = 0;

      // 3: bad header, then bad opcode byte
      tick(1);
      for (int i = 0; i < MEMSZ; i++) mem[i] = 8'h00;
      mem[0] = 8'h03; mem[1] = 8'h02;
      do_run(-1, 1'b0);
      tick(1);
      mem[0] = 8'h02; mem[1] = 8'h40; mem[2] = 8'h11; mem[3] = 8'h22; mem[4] = 8'hFF;
      do_run(-1, 1'b0);

      // 4: record straddling the top of memory on the wrap instance
      wmem[1022] = 8'h02; wmem[1023] = 8'h01; wmem[0] = 8'hAA; wmem[1] = 8'h55; wmem[2] = 8'hFF;
      model_run(1'b1, 1022, 100000, nb, oc);
      wrd_cnt = 0; w_enable = 1'b1; k = 0;
      while (k < 200 && (k == 0 || w_running)) begin tick(1); k++; end
      chk("w_timeout", 32'(w_running), 32'h0);
      w_enable = 1'b0;
      tick(3);
      chk("w_queue_empty", 32'(wexp_q.size()), 32'h0);
      chk("w_rd_count", 32'(wrd_cnt), 32'(nb));
      chk("w_halted", 32'(w_halted), 32'h1);

      // 5: asynchronous reset during the operand-A request
      load_t1(); rd_cnt = 0;
      enable = 1'b1;
      tick(5);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_ctl", 32'({mem_rd, mem_addr, ins_valid, ins_nops, running, halted, err_illegal}), 32'h0);
      chk("arst_ins", 32'({ins_opcode, ins_op_a, ins_op_b}), 32'h0);
      enable = 1'b0;
      #3 rst_n = 1'b1;
      saved = rd_cnt;
      tick(4);
      chk("no_rd_after_rst", 32'(rd_cnt), 32'(saved));
      do_run(-1, 1'b1);

      // 6: enable dropped mid-record
      tick(1);
      do_run(4, 1'b0);
      saved = rd_cnt;
      tick(10);
      chk("idle_no_rd", 32'(rd_cnt), 32'(saved));

      // Randomised programs with random back-pressure
      rmode = 1;
      for (int it = 0; it < 40; it++) begin
         for (int i = 0; i < 256; i++) mem[i] = 8'($urandom_range(0, 255));
         p = 0;
         n = $urandom_range(1, 6);
         for (int r = 0; r < n; r++) begin
            h = ($urandom_range(0, 1) == 1) ? 8'h02 : 8'h01;
            mem[p] = h; p++;
            mem[p] = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(64, 255))
                                                 : 8'($urandom_range(0, 63));
            p++;
            mem[p] = 8'($urandom_range(0, 255)); p++;
            if (h == 8'h02) begin mem[p] = 8'($urandom_range(0, 255)); p++; end
         end
         case ($urandom_range(0, 7))
            0:       mem[p] = 8'h00;
            1:       mem[p] = 8'h03;
            default: mem[p] = 8'hFF;
         endcase
         tick(1);
         do_run((it % 5 == 4) ? $urandom_range(3, 4) : -1, 1'b0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
